// File: rtl/trig_capture_ctrl.sv
// rtl/trig_capture_ctrl.sv - pre/post-trigger sample capture controller for a circular buffer
module trig_capture_ctrl #(
  parameter int DEPTH = 640,
  parameter int AW    = 10
) (
  input  logic          CLOCK_50,
  input  logic          reset_n,
  input  logic          sample_valid,
  input  logic [11:0]   sample,
  input  logic [11:0]   trig,
  input  logic          rising,
  input  logic [AW-1:0] post_count,
  input  logic          arm,
  input  logic          force_trig,
  input  logic          ack,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [11:0]   wr_data,
  output logic [AW-1:0] trig_addr,
  output logic [AW-1:0] start_addr,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE, S_PREFILL, S_WAIT_TRIG, S_POST, S_DONE
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [11:0]   lvl_q, lvl_d;
  logic          rising_q, rising_d;
  logic [AW-1:0] post_q, post_d;
  logic [11:0]   prev_q, prev_d;
  logic          prev_valid_q, prev_valid_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [11:0]   wr_data_q, wr_data_d;
  logic [AW-1:0] trig_addr_q, trig_addr_d;
  logic [AW-1:0] start_addr_q, start_addr_d;

  logic [AW-1:0] ptr_next;
  logic [AW-1:0] post_clamp;
  logic          hit_rise, hit_fall, hit, accept;

  assign ptr_next   = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
  assign post_clamp = (post_count == '0) ? AW'(1) :
                      (post_count > LAST) ? LAST : post_count;
  assign hit_rise   = prev_valid_q && (prev_q < lvl_q) && (sample >= lvl_q);
  assign hit_fall   = prev_valid_q && (prev_q > lvl_q) && (sample <= lvl_q);
  assign hit        = force_trig || (rising_q ? hit_rise : hit_fall);
  assign accept     = sample_valid &&
                      (state_q == S_PREFILL || state_q == S_WAIT_TRIG || state_q == S_POST);

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    lvl_d        = lvl_q;
    rising_d     = rising_q;
    post_d       = post_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    trig_addr_d  = trig_addr_q;
    start_addr_d = start_addr_q;

    if (accept) begin
      wr_en_d      = 1'b1;
      wr_addr_d    = ptr_q;
      wr_data_d    = sample;
      ptr_d        = ptr_next;
      prev_d       = sample;
      prev_valid_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (arm) begin
          lvl_d        = trig;
          rising_d     = rising;
          post_d       = post_clamp;
          ptr_d        = '0;
          cnt_d        = '0;
          prev_d       = '0;
          prev_valid_d = 1'b0;
          state_d      = S_PREFILL;
        end
      end
      S_PREFILL: begin
        // cnt_q counts writes before this one; LAST - post_q = DEPTH - post - 1
        if (sample_valid) begin
          if (cnt_q == LAST - post_q) begin
            cnt_d   = '0;
            state_d = S_WAIT_TRIG;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_WAIT_TRIG: begin
        if (sample_valid && hit) begin
          trig_addr_d = ptr_q;
          cnt_d       = AW'(1);
          if (post_q == AW'(1)) begin
            start_addr_d = ptr_next;
            state_d      = S_DONE;
          end else begin
            state_d = S_POST;
          end
        end
      end
      S_POST: begin
        if (sample_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q + 1'b1 == post_q) begin
            start_addr_d = ptr_next;
            state_d      = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      lvl_q        <= '0;
      rising_q     <= 1'b0;
      post_q       <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      lvl_q        <= lvl_d;
      rising_q     <= rising_d;
      post_q       <= post_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      trig_addr_q  <= trig_addr_d;
      start_addr_q <= start_addr_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign trig_addr  = trig_addr_q;
  assign start_addr = start_addr_q;
  assign busy       = (state_q == S_PREFILL) || (state_q == S_WAIT_TRIG) || (state_q == S_POST);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_trig_capture_ctrl.sv
// tb/tb_trig_capture_ctrl.sv - self-checking bench for trig_capture_ctrl
module tb_trig_capture_ctrl;

  localparam int DEPTH = 16;
  localparam int AW    = 5;
  localparam int N     = 48;

  logic          CLOCK_50 = 1'b0;
  logic          reset_n, sample_valid, rising, arm, force_trig, ack;
  logic [11:0]   sample, trig;
  logic [AW-1:0] post_count;
  logic          wr_en, busy, done;
  logic [AW-1:0] wr_addr, trig_addr, start_addr;
  logic [11:0]   wr_data;

  trig_capture_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .sample_valid(sample_valid), .sample(sample),
    .trig(trig), .rising(rising), .post_count(post_count), .arm(arm), .force_trig(force_trig),
    .ack(ack), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .trig_addr(trig_addr),
    .start_addr(start_addr), .busy(busy), .done(done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    string       tag;
    int          post;
    logic [11:0] lvl;
    bit          rise;
    logic [11:0] lo, hi;
    int          k1, ff, arm_at;
    bit          ack_arm;
    int          e_ta, e_sa, e_wr;
  } vec_t;

  int            n_vec = 0, n_err = 0;
  logic [11:0]   smp [N];
  logic [AW-1:0] wq_a [$];
  logic [11:0]   wq_d [$];
  bit            mon_on = 0, done_seen = 0, done_first_wr = 0;
  int            done_first_writes = -1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLOCK_50);
    if (mon_on) begin
      if (wr_en) begin
        wq_a.push_back(wr_addr);
        wq_d.push_back(wr_data);
      end
      if (done && !done_seen) begin
        done_seen         = 1;
        done_first_writes = wq_a.size();
        done_first_wr     = wr_en;
      end
    end
  endtask

  task automatic feed(input logic [11:0] s, input bit f, input bit a);
    sample_valid = 1'b1; sample = s; force_trig = f; arm = a;
    tick();
    sample_valid = 1'b0; force_trig = 1'b0; arm = 1'b0;
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic do_arm(input int p, input logic [11:0] tl, input bit r);
    wq_a.delete(); wq_d.delete();
    done_seen = 0; done_first_writes = -1; done_first_wr = 0; mon_on = 1;
    trig = tl; rising = r; post_count = AW'(p); arm = 1'b1;
    tick();
    arm = 1'b0;
    // scramble the config inputs: the capture must keep the values latched at arm
    trig = 12'($urandom); rising = 1'($urandom); post_count = AW'($urandom);
  endtask

  // Reference: expected trigger index, trigger/start addresses and write count
  function automatic void model(input int p, input logic [11:0] tl, input bit r, input int ff,
                                output int ta, output int sa, output int nw);
    int pc, ti;
    bit f, c;
    pc = (p == 0) ? 1 : ((p >= DEPTH) ? DEPTH - 1 : p);
    ti = -1;
    for (int i = DEPTH - pc; i < N && ti < 0; i++) begin
      f = (ff >= 0) && (i >= ff);
      c = r ? (smp[i-1] < tl && smp[i] >= tl) : (smp[i-1] > tl && smp[i] <= tl);
      if (f || c) ti = i;
    end
    ta = ti % DEPTH;
    nw = ti + pc;
    sa = nw % DEPTH;
  endfunction

  task automatic run_cap(input string tag, input int p, input logic [11:0] tl, input bit r,
                         input int ff, input int arm_at, input bit ack_arm,
                         input int e_ta, input int e_sa, input int e_wr);
    int bad;
    do_arm(p, tl, r);
    for (int i = 0; i < N; i++) feed(smp[i], (ff >= 0) && (i >= ff), i == arm_at);
    tick(); tick();
    bad = 0;
    for (int i = 0; i < wq_a.size() && i < e_wr; i++)
      if (wq_a[i] != AW'(i % DEPTH) || wq_d[i] != smp[i]) bad++;
    chk({tag, " write_count"}, wq_a.size(), e_wr);
    chk({tag, " bad_writes"}, bad, 0);
    chk({tag, " trig_addr"}, trig_addr, e_ta);
    chk({tag, " start_addr"}, start_addr, e_sa);
    chk({tag, " done"}, done, 1);
    chk({tag, " busy_in_done"}, busy, 0);
    chk({tag, " done_first_writes"}, done_first_writes, e_wr);
    chk({tag, " done_with_last_wr_en"}, done_first_wr, 1);
    ack = 1'b1; arm = ack_arm;
    tick();
    ack = 1'b0; arm = 1'b0;
    chk({tag, " done_after_ack"}, done, 0);
    chk({tag, " busy_after_ack"}, busy, 0);
    feed(12'h123, 1'b0, 1'b0);
    feed(12'h456, 1'b1, 1'b0);
    tick();
    chk({tag, " idle_no_writes"}, wq_a.size(), e_wr);
    mon_on = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl [7];
    int   ta, sa, nw, p, ff, aa;
    logic [11:0] tl;
    bit   r, aq;

    tbl[0] = '{"rise",      4, 12'h800, 1, 12'h100, 12'h900, 20, -1, -1, 0,  4, 8, 24};
    tbl[1] = '{"fall_eq",   4, 12'h400, 0, 12'h500, 12'h400, 20, -1, -1, 1,  4, 8, 24};
    tbl[2] = '{"prefill",   4, 12'h800, 1, 12'h100, 12'h900,  3, 15, -1, 0, 15, 3, 19};
    tbl[3] = '{"force",     4, 12'h800, 1, 12'h100, 12'h100, 99,  0, -1, 0, 12, 0, 16};
    tbl[4] = '{"post0",     0, 12'h800, 1, 12'h100, 12'h900, 20, -1, -1, 0,  4, 5, 21};
    tbl[5] = '{"post20",   20, 12'h800, 1, 12'h100, 12'h900,  5, -1, -1, 0,  5, 4, 20};
    tbl[6] = '{"arm_post",  4, 12'h800, 1, 12'h100, 12'h900, 20, -1, 22, 0,  4, 8, 24};

    reset_n = 1'b0; sample_valid = 1'b0; sample = '0; trig = '0; rising = 1'b0;
    post_count = '0; arm = 1'b0; force_trig = 1'b0; ack = 1'b0;
    tick(); tick();
    chk("reset wr_en", wr_en, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset outs", {wr_addr, wr_data, trig_addr, start_addr}, 0);
    reset_n = 1'b1;
    tick();

    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < N; i++) smp[i] = (i >= tbl[v].k1) ? tbl[v].hi : tbl[v].lo;
      run_cap(tbl[v].tag, tbl[v].post, tbl[v].lvl, tbl[v].rise, tbl[v].ff, tbl[v].arm_at,
              tbl[v].ack_arm, tbl[v].e_ta, tbl[v].e_sa, tbl[v].e_wr);
    end

    // reset in the middle of POST abandons the capture
    for (int i = 0; i < N; i++) smp[i] = (i >= 9) ? 12'h900 : 12'h100;
    do_arm(8, 12'h800, 1'b1);
    for (int i = 0; i < 12; i++) feed(smp[i], 1'b0, 1'b0);
    chk("mid_post busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_post_rst wr_en", wr_en, 0);
    chk("mid_post_rst busy_done", {busy, done}, 0);
    chk("mid_post_rst outs", {wr_addr, wr_data, trig_addr, start_addr}, 0);
    tick();
    reset_n = 1'b1;
    tick();
    wq_a.delete(); wq_d.delete();
    for (int i = 0; i < 6; i++) feed(12'h900, 1'b1, 1'b0);
    tick();
    chk("after_rst no_writes", wq_a.size(), 0);
    chk("after_rst busy", busy, 0);
    mon_on = 0;

    for (int t = 0; t < 14; t++) begin
      for (int i = 0; i < N; i++) smp[i] = 12'($urandom_range(0, 4095));
      p  = $urandom_range(0, 31);
      tl = 12'($urandom_range(0, 4095));
      r  = 1'($urandom);
      ff = $urandom_range(16, 30);
      aa = ($urandom_range(0, 1) == 1) ? $urandom_range(0, N - 1) : -1;
      aq = 1'($urandom);
      model(p, tl, r, ff, ta, sa, nw);
      run_cap($sformatf("rnd%0d", t), p, tl, r, ff, aa, aq, ta, sa, nw);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
